// File: rtl/tmon_pkg.sv
// Shared temperature-monitor package: data width, boolean type and the
// saturating clamp used for trend and noisy temperature values.
package tmon_pkg;

    localparam int TEMP_W = 8;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_t;

    // Saturate a signed, widened value into [lo, hi].
    function automatic logic [TEMP_W-1:0] clamp_temp(
        input logic signed [TEMP_W+1:0] v,
        input logic        [TEMP_W-1:0] lo,
        input logic        [TEMP_W-1:0] hi
    );
        logic [TEMP_W-1:0] r;
        if (v < $signed({2'b00, lo})) begin
            r = lo;
        end else if (v > $signed({2'b00, hi})) begin
            r = hi;
        end else begin
            r = v[TEMP_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tmon_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the temperature noise
// source; advances only when en is high.
module tmon_lfsr (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic        fb_s;

    assign fb_s = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

    // Shift register state: load seed on reset, step once per enable.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q_q <= seed;
        end else if (en) begin
            q_q <= {q_q[14:0], fb_s};
        end else begin
            q_q <= q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/temp_sensor.sv
// Synthetic temperature sensor: emits a triangle-wave temperature sample
// every SAMPLE_DIV clocks together with a one-cycle tick.
// Optional feature macro: TEMP_NOISE_EN adds LFSR noise of -2..+1 to temp.
module temp_sensor
    import tmon_pkg::*;
#(
    parameter int unsigned        SAMPLE_DIV = 4,
    parameter logic [TEMP_W-1:0]  TEMP_INIT  = 8'd25,
    parameter logic [TEMP_W-1:0]  TEMP_MIN   = 8'd0,
    parameter logic [TEMP_W-1:0]  TEMP_MAX   = 8'd100,
    parameter logic [TEMP_W-1:0]  STEP       = 8'd1,
    parameter logic [15:0]        LFSR_SEED  = 16'hACE1
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              tick,
    output logic [TEMP_W-1:0] temp
);

    typedef enum logic {
        RISE = 1'b0,
        FALL = 1'b1
    } dir_t;

    localparam logic [15:0] CNT_LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0]       cnt_q, cnt_d;
    logic              tick_q;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic [TEMP_W-1:0] trend_q, trend_d;
    dir_t              dir_q, dir_d;
    bool_t             wrap_s;
    logic [TEMP_W:0]   inc_s, dec_s, min_step_s;

    assign wrap_s     = (cnt_q == CNT_LAST) ? TRUE : FALSE;
    assign cnt_d      = (wrap_s == TRUE) ? 16'd0 : (cnt_q + 16'd1);
    assign inc_s      = {1'b0, trend_q} + {1'b0, STEP};
    assign dec_s      = {1'b0, trend_q} - {1'b0, STEP};
    assign min_step_s = {1'b0, TEMP_MIN} + {1'b0, STEP};

    // Triangle-wave trend and direction, stepped only on the wrap edge.
    always_comb begin
        trend_d = trend_q;
        dir_d   = dir_q;
        if (wrap_s == TRUE) begin
            case (dir_q)
                RISE: begin
                    if (inc_s >= {1'b0, TEMP_MAX}) begin
                        trend_d = TEMP_MAX;
                        dir_d   = FALL;
                    end else begin
                        trend_d = clamp_temp($signed({1'b0, inc_s}), TEMP_MIN, TEMP_MAX);
                    end
                end
                FALL: begin
                    if ({1'b0, trend_q} <= min_step_s) begin
                        trend_d = TEMP_MIN;
                        dir_d   = RISE;
                    end else begin
                        trend_d = clamp_temp($signed({1'b0, dec_s}), TEMP_MIN, TEMP_MAX);
                    end
                end
                default: begin
                    trend_d = TEMP_INIT;
                    dir_d   = RISE;
                end
            endcase
        end else begin
            trend_d = trend_q;
            dir_d   = dir_q;
        end
    end

`ifdef TEMP_NOISE_EN
    logic [15:0]              lfsr_q;
    logic signed [TEMP_W+1:0] noise_s;

    tmon_lfsr u_lfsr (
        .Clock (Clock),
        .Reset (Reset),
        .en    (wrap_s == TRUE),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Two LSBs of the LFSR read as a signed offset in -2..+1.
    assign noise_s = $signed({{TEMP_W{lfsr_q[1]}}, lfsr_q[1:0]});

    // Noisy sample: new trend plus offset, saturated to the legal range.
    always_comb begin
        if (wrap_s == TRUE) begin
            temp_d = clamp_temp($signed({2'b00, trend_d}) + noise_s, TEMP_MIN, TEMP_MAX);
        end else begin
            temp_d = temp_q;
        end
    end
`else
    // Clean sample: temp follows the new trend exactly.
    always_comb begin
        if (wrap_s == TRUE) begin
            temp_d = trend_d;
        end else begin
            temp_d = temp_q;
        end
    end
`endif

    // All sensor state; reset dominates any simultaneous wrap edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q   <= 16'd0;
            tick_q  <= 1'b0;
            temp_q  <= TEMP_INIT;
            trend_q <= TEMP_INIT;
            dir_q   <= RISE;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= (wrap_s == TRUE);
            temp_q  <= temp_d;
            trend_q <= trend_d;
            dir_q   <= dir_d;
        end
    end

    assign tick = tick_q;
    assign temp = temp_q;

endmodule

// File: tb/tb_temp_sensor.sv
// Directed bench for temp_sensor: default, high-start and narrow-range
// instances driven in lock-step, plus a mid-period reset pulse.
module tb_temp_sensor;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic       tick0, tick1, tick2;
    logic [7:0] temp0, temp1, temp2;

    int checks = 0;
    int errors = 0;

    int exp0[5] = '{26, 27, 28, 29, 30};
    int exp1[6] = '{99, 100, 99, 98, 97, 96};
    int exp2[6] = '{2, 3, 2, 1, 0, 1};

    always #5 clk = ~clk;

    temp_sensor u_dut0 (
        .Clock (clk), .Reset (rst_a), .tick (tick0), .temp (temp0)
    );

    temp_sensor #(.TEMP_INIT(8'd98)) u_dut1 (
        .Clock (clk), .Reset (rst_b), .tick (tick1), .temp (temp1)
    );

    temp_sensor #(.TEMP_INIT(8'd1), .TEMP_MIN(8'd0), .TEMP_MAX(8'd3)) u_dut2 (
        .Clock (clk), .Reset (rst_b), .tick (tick2), .temp (temp2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Exact match without noise; trend-2..trend+1 within [tmin,tmax] with noise.
    task automatic chk_temp(input string tag, input int obs, input int trend,
                            input int tmin, input int tmax);
`ifdef TEMP_NOISE_EN
        int lo;
        int hi;
        lo = (trend - 2 < tmin) ? tmin : trend - 2;
        hi = (trend + 1 > tmax) ? tmax : trend + 1;
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
`else
        chk(tag, obs, trend);
`endif
    endtask

    initial begin
        int prev0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset held for 4 clocks.
        repeat (4) begin
            @(negedge clk);
            chk("rst_tick0", int'(tick0), 0);
            chk("rst_temp0", int'(temp0), 25);
        end
        chk("rst_temp1", int'(temp1), 98);
        chk("rst_temp2", int'(temp2), 1);

        rst_a = 1'b0;
        rst_b = 1'b0;
        prev0 = 25;

        // Five full periods on all instances.
        for (int k = 0; k < 5; k++) begin
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c < 4) begin
                    chk($sformatf("tick0_low_p%0d_c%0d", k, c), int'(tick0), 0);
                    chk($sformatf("temp0_hold_p%0d_c%0d", k, c), int'(temp0), prev0);
                end else begin
                    chk($sformatf("tick0_p%0d", k), int'(tick0), 1);
                    chk($sformatf("tick1_p%0d", k), int'(tick1), 1);
                    chk($sformatf("tick2_p%0d", k), int'(tick2), 1);
                    chk_temp($sformatf("temp0_p%0d", k), int'(temp0), exp0[k], 0, 100);
                    chk_temp($sformatf("temp1_p%0d", k), int'(temp1), exp1[k], 0, 100);
                    chk_temp($sformatf("temp2_p%0d", k), int'(temp2), exp2[k], 0, 3);
                    prev0 = int'(temp0);
                end
            end
        end

        // Two clocks into the sixth period, pulse dut0 reset between edges.
        repeat (2) @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        chk("async_rst_tick0", int'(tick0), 0);
        chk("async_rst_temp0", int'(temp0), 25);
        @(negedge clk);
        chk("rst_hold_tick0", int'(tick0), 0);
        chk("rst_hold_temp0", int'(temp0), 25);
        @(negedge clk);
        chk("rst_wrap_tick0", int'(tick0), 0);
        chk("rst_wrap_temp0", int'(temp0), 25);
        chk("tick1_p5", int'(tick1), 1);
        chk("tick2_p5", int'(tick2), 1);
        chk_temp("temp1_p5", int'(temp1), exp1[5], 0, 100);
        chk_temp("temp2_p5", int'(temp2), exp2[5], 0, 3);
        rst_a = 1'b0;

        // First tick after release comes on the fourth rising edge.
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c < 4) begin
                chk($sformatf("post_rst_tick0_c%0d", c), int'(tick0), 0);
            end else begin
                chk("post_rst_tick0", int'(tick0), 1);
                chk_temp("post_rst_temp0", int'(temp0), 26, 0, 100);
            end
        end

`ifdef TEMP_NOISE_EN
        begin
            int trend;
            int rising;
            int obs;
            int lo;
            int hi;
            int nd;
            logic [3:0] seen;
            trend  = 26;
            rising = 1;
            seen   = 4'b0000;
            for (int i = 0; i < 1000; i++) begin
                repeat (4) @(negedge clk);
                if (rising == 1) begin
                    if (trend + 1 >= 100) begin
                        trend  = 100;
                        rising = 0;
                    end else begin
                        trend = trend + 1;
                    end
                end else begin
                    if (trend <= 1) begin
                        trend  = 0;
                        rising = 1;
                    end else begin
                        trend = trend - 1;
                    end
                end
                obs = int'(temp0);
                lo  = (trend - 2 < 0) ? 0 : trend - 2;
                hi  = (trend + 1 > 100) ? 100 : trend + 1;
                checks++;
                assert (tick0 === 1'b1 && obs >= lo && obs <= hi) else begin
                    errors++;
                    $error("FAIL noise_s%0d: observed tick=%0b temp=%0d expected tick=1 temp %0d..%0d",
                           i, tick0, obs, lo, hi);
                end
                if (obs - trend >= -2 && obs - trend <= 1) begin
                    seen[obs - trend + 2] = 1'b1;
                end
            end
            nd = int'(seen[0]) + int'(seen[1]) + int'(seen[2]) + int'(seen[3]);
            chk("noise_distinct_ge3", (nd >= 3) ? 1 : 0, 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
